// File: rtl/ddma_seq_pkg.sv
// ==========================================================================
// ddma_seq_pkg : shared types for the DDMA send-descriptor sequencer
// Rev 1.0
// ==========================================================================
`default_nettype none

package ddma_seq_pkg;

  // Descriptor field width; the sequencer's MEMORY_WIDTH is expected to match.
  localparam int DESC_FIELD_W = 32;
  localparam int DONE_CNT_W   = 16;

  typedef struct packed {
    logic [DESC_FIELD_W-1:0] dest;
    logic [DESC_FIELD_W-1:0] addr;
    logic [DESC_FIELD_W-1:0] size;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/ddma_desc_fifo.sv
// ==========================================================================
// ddma_desc_fifo : synchronous descriptor FIFO, head read combinationally
// Rev 1.0
// ==========================================================================
`default_nettype none

module ddma_desc_fifo
  import ddma_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  desc_t                  push_data,
  input  logic                   pop,
  input  logic                   flush,
  output desc_t                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  desc_t          mem [DEPTH];
  logic  [AW-1:0] wr_ptr;
  logic  [AW-1:0] rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddma_cmd_sequencer.sv
// ==========================================================================
// ddma_cmd_sequencer : queues send descriptors and launches them on the DDMA
// Rev 1.0
// ==========================================================================
`default_nettype none

module ddma_cmd_sequencer
  import ddma_seq_pkg::*;
#(
  parameter int MEMORY_WIDTH   = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push_in,
  input  logic [MEMORY_WIDTH-1:0] push_dest_in,
  input  logic [MEMORY_WIDTH-1:0] push_addr_in,
  input  logic [MEMORY_WIDTH-1:0] push_size_in,
  input  logic                    flush_in,
  input  logic                    irq_ack_in,
  output logic                    full_out,
  output logic [$clog2(DEPTH):0]  count_out,
  output logic                    busy_out,
  output logic                    irq_out,
  output logic                    overflow_out,
  output logic                    timeout_out,
  output logic [DONE_CNT_W-1:0]   done_count_out,
  output logic [MEMORY_WIDTH-1:0] ddma_dest_out,
  output logic [MEMORY_WIDTH-1:0] ddma_addr_out,
  output logic [MEMORY_WIDTH-1:0] ddma_size_out,
  output logic                    ddma_cmd_out,
  input  logic                    ddma_irq_send_in
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_t      state;
  logic [WD_W-1:0] watchdog;
  logic            xfer_ok;
  desc_t           push_entry;
  desc_t           head;
  logic            fifo_empty;
  logic            pop;

  assign push_entry = '{dest: DESC_FIELD_W'(push_dest_in),
                        addr: DESC_FIELD_W'(push_addr_in),
                        size: DESC_FIELD_W'(push_size_in)};

  // A flush cycle never launches, so the flushed head cannot escape.
  assign pop      = (state == IDLE) && !fifo_empty && !flush_in;
  assign busy_out = (state != IDLE);

  ddma_desc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_in),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (flush_in),
    .head     (head),
    .full     (full_out),
    .empty    (fifo_empty),
    .count    (count_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      watchdog       <= '0;
      xfer_ok        <= 1'b0;
      irq_out        <= 1'b0;
      overflow_out   <= 1'b0;
      timeout_out    <= 1'b0;
      done_count_out <= '0;
      ddma_dest_out  <= '0;
      ddma_addr_out  <= '0;
      ddma_size_out  <= '0;
      ddma_cmd_out   <= 1'b0;
    end else begin
      if (push_in && full_out && !flush_in) begin
        overflow_out <= 1'b1;
      end
      // Ack first so a same-cycle drain event below takes precedence.
      if (irq_ack_in) begin
        irq_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            ddma_dest_out <= MEMORY_WIDTH'(head.dest);
            ddma_addr_out <= MEMORY_WIDTH'(head.addr);
            ddma_size_out <= MEMORY_WIDTH'(head.size);
            ddma_cmd_out  <= 1'b1;
            watchdog      <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          watchdog <= watchdog + WD_W'(1);
          if (ddma_irq_send_in) begin
            ddma_cmd_out <= 1'b0;
            xfer_ok      <= 1'b1;
            state        <= RELEASE;
          end else if (watchdog == WD_LAST) begin
            ddma_cmd_out <= 1'b0;
            xfer_ok      <= 1'b0;
            timeout_out  <= 1'b1;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ddma_irq_send_in) begin
            state <= IDLE;
            if (xfer_ok) begin
              done_count_out <= done_count_out + DONE_CNT_W'(1);
            end
            if (count_out == '0 && !push_in) begin
              irq_out <= 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          ddma_cmd_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddma_cmd_sequencer.sv
// ==========================================================================
// tb_ddma_cmd_sequencer : bench for ddma_cmd_sequencer with lockstep model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_ddma_cmd_sequencer;

  localparam int MW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [MW-1:0] dest;
    logic [MW-1:0] addr;
    logic [MW-1:0] size;
  } d_t;

  typedef struct {
    bit push;
    bit flush;
    int count;
    bit full;
    bit cmd;
    bit ovf;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          push_in;
  logic [MW-1:0] push_dest_in;
  logic [MW-1:0] push_addr_in;
  logic [MW-1:0] push_size_in;
  logic          flush_in;
  logic          irq_ack_in;
  logic          full_out;
  logic [CW-1:0] count_out;
  logic          busy_out;
  logic          irq_out;
  logic          overflow_out;
  logic          timeout_out;
  logic [15:0]   done_count_out;
  logic [MW-1:0] ddma_dest_out;
  logic [MW-1:0] ddma_addr_out;
  logic [MW-1:0] ddma_size_out;
  logic          ddma_cmd_out;
  logic          ddma_irq_send_in;

  always #5 clock = ~clock;

  ddma_cmd_sequencer #(
    .MEMORY_WIDTH  (MW),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .push_in         (push_in),
    .push_dest_in    (push_dest_in),
    .push_addr_in    (push_addr_in),
    .push_size_in    (push_size_in),
    .flush_in        (flush_in),
    .irq_ack_in      (irq_ack_in),
    .full_out        (full_out),
    .count_out       (count_out),
    .busy_out        (busy_out),
    .irq_out         (irq_out),
    .overflow_out    (overflow_out),
    .timeout_out     (timeout_out),
    .done_count_out  (done_count_out),
    .ddma_dest_out   (ddma_dest_out),
    .ddma_addr_out   (ddma_addr_out),
    .ddma_size_out   (ddma_size_out),
    .ddma_cmd_out    (ddma_cmd_out),
    .ddma_irq_send_in(ddma_irq_send_in)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: a descriptor queue plus the transfer currently on the bus.
  d_t          m_q[$];
  bit          m_cmd, m_rel, m_ok, m_irq, m_ovf, m_tmo;
  int          m_age;
  int unsigned m_done;
  d_t          m_out;

  function automatic void model_reset();
    m_q.delete();
    m_cmd = 0; m_rel = 0; m_ok = 0; m_irq = 0; m_ovf = 0; m_tmo = 0;
    m_age = 0; m_done = 0; m_out = '0;
  endfunction

  function automatic void model_edge(input bit p, input d_t pd, input bit f,
                                     input bit a, input bit s);
    int n;
    bit was_idle, was_issue, was_rel;
    n         = m_q.size();
    was_idle  = !m_cmd && !m_rel;
    was_issue = m_cmd;
    was_rel   = m_rel;
    if (a) m_irq = 0;
    if (was_rel && !s) begin
      m_rel = 0;
      if (m_ok) m_done = (m_done + 1) % 65536;
      if (n == 0 && !p) m_irq = 1;
    end
    if (was_issue) begin
      m_age++;
      if (s) begin
        m_cmd = 0; m_rel = 1; m_ok = 1;
      end else if (m_age == TMO) begin
        m_cmd = 0; m_rel = 1; m_ok = 0; m_tmo = 1;
      end
    end
    if (f) begin
      m_q.delete();
    end else begin
      if (was_idle && n > 0) begin
        m_out = m_q.pop_front();
        m_cmd = 1;
        m_age = 0;
      end
      if (p) begin
        if (n < DEPTH) m_q.push_back(pd);
        else m_ovf = 1;
      end
    end
  endfunction

  function automatic void check_all();
    check("count_out", count_out, m_q.size());
    check("full_out", full_out, m_q.size() == DEPTH);
    check("busy_out", busy_out, m_cmd || m_rel);
    check("irq_out", irq_out, m_irq);
    check("overflow_out", overflow_out, m_ovf);
    check("timeout_out", timeout_out, m_tmo);
    check("done_count_out", done_count_out, m_done[15:0]);
    check("ddma_cmd_out", ddma_cmd_out, m_cmd);
    check("ddma_dest_out", ddma_dest_out, m_out.dest);
    check("ddma_addr_out", ddma_addr_out, m_out.addr);
    check("ddma_size_out", ddma_size_out, m_out.size);
  endfunction

  // DDMA responder: raises irq_send rise_dly cycles into cmd, drops it fall_dly after cmd falls.
  int rise_dly = 5, fall_dly = 2, hi_cnt = 0, lo_cnt = 0;
  bit never = 0, rand_mode = 0, prev_cmd = 0;
  int cmd_run = 0;
  d_t obs_q[$];
  int runs_q[$];

  task automatic tick(input bit p, input d_t pd, input bit f, input bit a);
    if (!reset && !never) begin
      if (ddma_cmd_out) lo_cnt = 0; else hi_cnt = 0;
      if (ddma_cmd_out && !ddma_irq_send_in) begin
        hi_cnt++;
        if (hi_cnt >= rise_dly) ddma_irq_send_in = 1'b1;
      end else if (!ddma_cmd_out && ddma_irq_send_in) begin
        lo_cnt++;
        if (lo_cnt >= fall_dly) ddma_irq_send_in = 1'b0;
      end
    end
    push_in = p;
    {push_dest_in, push_addr_in, push_size_in} = pd;
    flush_in   = f;
    irq_ack_in = a;
    @(posedge clock);
    if (reset) model_reset();
    else model_edge(p, pd, f, a, ddma_irq_send_in);
    #1;
    check_all();
    if (ddma_cmd_out) begin
      if (!prev_cmd) begin
        obs_q.push_back({ddma_dest_out, ddma_addr_out, ddma_size_out});
        if (rand_mode) begin
          rise_dly = $urandom_range(0, 19);
          fall_dly = $urandom_range(0, 3);
        end
      end
      cmd_run++;
    end else if (prev_cmd) begin
      runs_q.push_back(cmd_run);
      cmd_run = 0;
    end
    prev_cmd = ddma_cmd_out;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ddma_irq_send_in = 1'b0;
    hi_cnt = 0;
    lo_cnt = 0;
    tick(0, '0, 0, 0);
    reset = 1'b0;
    obs_q.delete();
    runs_q.delete();
    cmd_run  = 0;
    prev_cmd = 0;
  endtask

  task automatic wait_idle(input int lim, input bit a, input string nm);
    int i;
    i = 0;
    while ((busy_out || count_out != 0) && i < lim) begin
      tick(0, '0, 0, a);
      i++;
    end
    check({nm, "_drain_bound"}, busy_out || (count_out != 0), 0);
  endtask

  d_t   D0, D1, D2, D3;
  vec_t tbl[8];

  initial begin
    D0 = '{dest: 32'h0102, addr: 32'h4000_0100, size: 32'd16};
    D1 = '{dest: 32'h0203, addr: 32'h4000_0200, size: 32'd32};
    D2 = '{dest: 32'h0304, addr: 32'h4000_0300, size: 32'd64};
    D3 = '{dest: 32'h0405, addr: 32'h4000_0400, size: 32'd128};
    //            push flush count full cmd ovf
    tbl[0] = '{1, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 1, 0};
    tbl[2] = '{1, 0, 2, 0, 1, 0};
    tbl[3] = '{1, 0, 3, 0, 1, 0};
    tbl[4] = '{1, 0, 4, 1, 1, 0};
    tbl[5] = '{1, 0, 4, 1, 1, 1};
    tbl[6] = '{0, 1, 0, 0, 1, 1};
    tbl[7] = '{0, 0, 0, 0, 1, 1};

    push_in = 0; flush_in = 0; irq_ack_in = 0; ddma_irq_send_in = 0;
    push_dest_in = '0; push_addr_in = '0; push_size_in = '0;
    model_reset();

    // Three launches in order, aggregated interrupt at the end.
    do_reset();
    check("reset_cmd", ddma_cmd_out, 0);
    check("reset_count", count_out, 0);
    check("reset_done", done_count_out, 0);
    rise_dly = 5; fall_dly = 2; never = 0;
    tick(1, D0, 0, 0);
    tick(1, D1, 0, 0);
    tick(1, D2, 0, 0);
    wait_idle(200, 0, "three");
    check("three_launches", obs_q.size(), 3);
    check("three_l0", obs_q.size() > 0 ? obs_q[0] : '0, D0);
    check("three_l1", obs_q.size() > 1 ? obs_q[1] : '0, D1);
    check("three_l2", obs_q.size() > 2 ? obs_q[2] : '0, D2);
    check("three_done", done_count_out, 3);
    check("three_irq", irq_out, 1);

    // Stalled DDMA: fill, overflow, then flush while the head is in flight.
    do_reset();
    never = 1;
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].push, d_t'{32'(i), 32'h5000_0000 + 32'(i), 32'd4}, tbl[i].flush, 0);
      check($sformatf("vec%0d_count", i), count_out, tbl[i].count);
      check($sformatf("vec%0d_full", i), full_out, tbl[i].full);
      check($sformatf("vec%0d_cmd", i), ddma_cmd_out, tbl[i].cmd);
      check($sformatf("vec%0d_ovf", i), overflow_out, tbl[i].ovf);
    end
    wait_idle(60, 0, "stall");

    // Watchdog: irq_send never arrives.
    do_reset();
    never = 1;
    tick(1, D0, 0, 0);
    tick(1, D1, 0, 0);
    wait_idle(200, 0, "tmo");
    check("tmo_run_len", runs_q.size() > 0 ? runs_q[0] : 0, TMO);
    check("tmo_flag", timeout_out, 1);
    check("tmo_done", done_count_out, 0);
    check("tmo_next_launch", obs_q.size() > 1 ? obs_q[1] : '0, D1);

    // Flush with a same-cycle push while the first transfer is in flight.
    do_reset();
    never = 0; rise_dly = 5; fall_dly = 2;
    tick(1, D0, 0, 0);
    tick(1, D1, 0, 0);
    tick(1, D2, 0, 0);
    tick(1, D3, 1, 0);
    check("flush_count", count_out, 0);
    check("flush_ovf", overflow_out, 0);
    wait_idle(100, 0, "flush");
    check("flush_launches", obs_q.size(), 1);
    check("flush_done", done_count_out, 1);
    check("flush_irq", irq_out, 1);

    // Ack handling: lone ack clears, ack coinciding with a set loses.
    tick(0, '0, 0, 1);
    check("ack_clear", irq_out, 0);
    tick(1, D0, 0, 1);
    wait_idle(100, 1, "ack");
    check("ack_set_wins", irq_out, 1);
    tick(0, '0, 0, 1);
    check("ack_lone", irq_out, 0);

    // Reset during ISSUE.
    do_reset();
    never = 1;
    tick(1, D0, 0, 0);
    tick(1, D1, 0, 0);
    tick(1, D2, 0, 0);
    tick(0, '0, 0, 0);
    check("rst_mid_cmd_before", ddma_cmd_out, 1);
    reset = 1'b1;
    ddma_irq_send_in = 1'b0;
    tick(1, D3, 0, 0);
    reset = 1'b0;
    check("rst_mid_cmd", ddma_cmd_out, 0);
    check("rst_mid_count", count_out, 0);
    check("rst_mid_busy", busy_out, 0);
    check("rst_mid_dest", ddma_dest_out, 0);
    tick(0, '0, 0, 0);
    check("rst_mid_no_launch", ddma_cmd_out, 0);

    // Randomized traffic against the model.
    do_reset();
    never = 0; rand_mode = 1;
    rise_dly = $urandom_range(0, 19);
    fall_dly = $urandom_range(0, 3);
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 2) == 0,
           d_t'{$urandom, $urandom, $urandom},
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0);
    end
    rand_mode = 0;
    wait_idle(300, 0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
